// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Receive-side parity checker for a serial link. A frame is DATA_W data bits,
// MSB first, followed by one parity bit. The data word is reassembled, the
// parity bit is checked against the selected sense (even or odd), and the
// result is presented for one cycle on data_valid.
//
// Parameters:
//   DATA_W      data bits per frame (1..16)
//   ODD_PARITY  0: total XOR of data+parity must be 0; 1: must be 1
//   CNT_W       width of the saturating parity-error counter
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   bit_in       serial data/parity bit, sampled when bit_valid=1
//   bit_valid    qualifies bit_in for one clock
//   frame_abort  synchronous discard of the frame in progress (wins over bit_valid)
//   data_out     last completed data word
//   data_valid   one-cycle pulse per completed frame
//   parity_err   parity result of the last completed frame
//   busy         high while a frame is partially received
//   err_count    saturating count of frames with parity errors
//
// Optional feature macro: SERIAL_PARITY_CHECKER_ERR_CNT_EN
//   defined   -> err_count counter is built
//   undefined -> no counter register, err_count tied to 0
module serial_parity_checker #(
   parameter int unsigned DATA_W     = 3,
   parameter bit          ODD_PARITY = 1'b0,
   parameter int unsigned CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              frame_abort,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              busy,
   output logic [CNT_W-1:0]  err_count
);

   // Bit counter only needs to hold 0..DATA_W-1; it clears on the last data bit.
   localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [0:0] S_DATA   = 1'b0;
   localparam logic [0:0] S_PARITY = 1'b1;

   logic [0:0]        state,  state_nxt;
   logic [BC_W-1:0]   bitcnt, bitcnt_nxt;
   logic [DATA_W-1:0] shreg,  shreg_nxt;
   logic              acc,    acc_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              perr_nxt;
   logic              valid_nxt;
   logic              busy_nxt;

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_DATA;
         bitcnt     <= '0;
         shreg      <= '0;
         acc        <= 1'b0;
         data_out   <= '0;
         parity_err <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitcnt     <= bitcnt_nxt;
         shreg      <= shreg_nxt;
         acc        <= acc_nxt;
         data_out   <= data_nxt;
         parity_err <= perr_nxt;
         data_valid <= valid_nxt;
         busy       <= busy_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      shreg_nxt  = shreg;
      acc_nxt    = acc;
      data_nxt   = data_out;
      perr_nxt   = parity_err;
      valid_nxt  = 1'b0;

      if (frame_abort) begin
         state_nxt  = S_DATA;
         bitcnt_nxt = '0;
         shreg_nxt  = '0;
         acc_nxt    = 1'b0;
      end else if (bit_valid) begin
         case (state)
            S_DATA: begin
               // Shift in from the LSB; the cast keeps the low DATA_W bits,
               // which also covers DATA_W == 1.
               shreg_nxt = DATA_W'({shreg, bit_in});
               acc_nxt   = acc ^ bit_in;
               if (bitcnt == BC_W'(DATA_W - 1)) begin
                  bitcnt_nxt = '0;
                  state_nxt  = S_PARITY;
               end else begin
                  bitcnt_nxt = bitcnt + BC_W'(1);
               end
            end
            S_PARITY: begin
               data_nxt  = shreg;
               perr_nxt  = (acc ^ bit_in) != ODD_PARITY;
               valid_nxt = 1'b1;
               acc_nxt   = 1'b0;
               shreg_nxt = '0;
               state_nxt = S_DATA;
            end
         endcase
      end

      // Registered copy of busy, computed from the next register values.
      busy_nxt = (state_nxt == S_PARITY) || (bitcnt_nxt != '0);
   end

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Saturating error counter, bumped on each completed frame with bad parity
   always_comb begin
      cnt_nxt = cnt;
      if (valid_nxt && perr_nxt && (cnt != '1)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   assign err_count = cnt;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Testbench for serial_parity_checker: an even-parity and an odd-parity
// instance share the same serial stimulus. Expected frame results are queued
// when a frame is issued; per-instance monitors pop and compare on data_valid.
module tb_serial_parity_checker;

   localparam int unsigned DATA_W = 3;
   localparam int unsigned CNT_W  = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              bit_in = 1'b0;
   logic              bit_valid = 1'b0;
   logic              frame_abort = 1'b0;

   logic [DATA_W-1:0] data_e, data_o;
   logic              dv_e, dv_o, perr_e, perr_o, busy_e, busy_o;
   logic [CNT_W-1:0]  cnt_e, cnt_o;

   int checks = 0;
   int failures = 0;
   int mcnt_e = 0;
   int mcnt_o = 0;
   exp_t q_e[$];
   exp_t q_o[$];

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_W(DATA_W), .ODD_PARITY(1'b0), .CNT_W(CNT_W)) dut_even (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .frame_abort(frame_abort), .data_out(data_e), .data_valid(dv_e),
      .parity_err(perr_e), .busy(busy_e), .err_count(cnt_e)
   );

   serial_parity_checker #(.DATA_W(DATA_W), .ODD_PARITY(1'b1), .CNT_W(CNT_W)) dut_odd (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
      .frame_abort(frame_abort), .data_out(data_o), .data_valid(dv_o),
      .parity_err(perr_o), .busy(busy_o), .err_count(cnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitors: every data_valid pulse must match the oldest queued frame
   always @(negedge clk) begin
      exp_t e;
      if (dv_e === 1'b1) begin
         if (q_e.size() == 0) begin
            chk("even_unexpected_valid", 32'(dv_e), 32'd0);
         end else begin
            e = q_e.pop_front();
            chk("even_data", 32'(data_e), 32'(e.data));
            chk("even_perr", 32'(perr_e), 32'(e.err));
            chk("even_cnt",  32'(cnt_e),  32'(e.cnt));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (dv_o === 1'b1) begin
         if (q_o.size() == 0) begin
            chk("odd_unexpected_valid", 32'(dv_o), 32'd0);
         end else begin
            e = q_o.pop_front();
            chk("odd_data", 32'(data_o), 32'(e.data));
            chk("odd_perr", 32'(perr_o), 32'(e.err));
            chk("odd_cnt",  32'(cnt_o),  32'(e.cnt));
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   // One valid bit, presented for exactly one clock; returns on a negedge.
   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Queue expected results; the odd instance's verdict is the inverse of even.
   task automatic push_exp(input logic [DATA_W-1:0] d, input logic err_even);
      exp_t e;
      logic err_odd;
      err_odd = ~err_even;
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
      if (err_even && mcnt_e < 15) mcnt_e++;
      if (err_odd  && mcnt_o < 15) mcnt_o++;
`endif
      e.data = d; e.err = err_even; e.cnt = CNT_W'(mcnt_e);
      q_e.push_back(e);
      e.err = err_odd; e.cnt = CNT_W'(mcnt_o);
      q_o.push_back(e);
   endtask

   // Send a frame MSB first with 'gap' idle cycles after each data bit;
   // busy must stay high through every gap.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                             input int gap, input logic err_even);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         send_bit(d[i]);
         for (int g = 0; g < gap; g++) begin
            chk("busy_gap_even", 32'(busy_e), 32'd1);
            chk("busy_gap_odd",  32'(busy_o), 32'd1);
            @(negedge clk);
         end
      end
      push_exp(d, err_even);
      send_bit(p);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data_even"}, 32'(data_e), 32'd0);
      chk({tag, "_dv_even"},   32'(dv_e),   32'd0);
      chk({tag, "_perr_even"}, 32'(perr_e), 32'd0);
      chk({tag, "_busy_even"}, 32'(busy_e), 32'd0);
      chk({tag, "_cnt_even"},  32'(cnt_e),  32'd0);
      chk({tag, "_data_odd"},  32'(data_o), 32'd0);
      chk({tag, "_busy_odd"},  32'(busy_o), 32'd0);
      chk({tag, "_cnt_odd"},   32'(cnt_o),  32'd0);
   endtask

   initial begin
      idle(2);
      check_all_zero("reset");
      reset = 1'b0;
      idle(1);

      // Directed frames: data, parity, expected even-mode error (hand computed)
      send_frame(3'b101, 1'b0, 0, 1'b0);   // 1^0^1^0 = 0
      send_frame(3'b111, 1'b0, 0, 1'b1);   // 1^1^1^0 = 1
      send_frame(3'b000, 1'b0, 0, 1'b0);   // 0
      send_frame(3'b011, 1'b1, 0, 1'b1);   // 0^1^1^1 = 1 -> odd ok
      send_frame(3'b011, 1'b0, 0, 1'b0);   // 0 -> odd error
      idle(1);
      chk("idle_busy_even", 32'(busy_e), 32'd0);

      // Abort after two data bits, with a simultaneous bit_valid that is dropped
      send_bit(1'b1);
      send_bit(1'b0);
      chk("pre_abort_busy", 32'(busy_e), 32'd1);
      bit_in = 1'b1; bit_valid = 1'b1; frame_abort = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0; frame_abort = 1'b0;
      chk("abort_busy_even", 32'(busy_e), 32'd0);
      chk("abort_busy_odd",  32'(busy_o), 32'd0);
      chk("abort_dv_even",   32'(dv_e),   32'd0);
      chk("abort_data_even", 32'(data_e), 32'(3'b011));
      chk("abort_perr_even", 32'(perr_e), 32'd0);
      chk("abort_perr_odd",  32'(perr_o), 32'd1);
      send_frame(3'b010, 1'b1, 0, 1'b0);   // 0^1^0^1 = 0

      // Saturation: 20 frames bad for even, then 20 bad for odd
      for (int k = 0; k < 20; k++) send_frame(3'b110, 1'b1, 0, 1'b1);
      for (int k = 0; k < 20; k++) send_frame(3'b110, 1'b0, 0, 1'b0);
      idle(1);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
      chk("sat_cnt_even", 32'(cnt_e), 32'd15);
      chk("sat_cnt_odd",  32'(cnt_o), 32'd15);
`else
      chk("sat_cnt_even", 32'(cnt_e), 32'd0);
      chk("sat_cnt_odd",  32'(cnt_o), 32'd0);
`endif

      // Gapped frames: identical results, busy held through gaps
      send_frame(3'b101, 1'b0, 3, 1'b0);
      send_frame(3'b111, 1'b0, 3, 1'b1);
      idle(1);

      // Asynchronous reset mid-frame, checked before the next rising edge
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      mcnt_e = 0;
      mcnt_o = 0;
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      send_frame(3'b101, 1'b0, 0, 1'b0);   // shift register and counter restart clean

      idle(3);
      chk("queue_even_empty", 32'(q_e.size()), 32'd0);
      chk("queue_odd_empty",  32'(q_o.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
